multicycle_cpu: RTL and testbench

Parametrised multi-cycle RV32I-subset core, successor to the single-cycle cpu.
- One shared datapath is sequenced by an FSM.
- Adds data memory load/store, branches, JAL, halt/illegal detection, x0 hardwired to zero, and a retire counter.
- Instruction ROM and data RAM depths are parametrised.
- Top-level block of the cpu/ testbench hierarchy.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/mc_control_fsm.sv | 125 ++++++++++++
 rtl/multicycle_cpu.sv | 124 ++++++++++++
 tb/tb_multicycle_cpu.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types, encodings and decode helpers for the multicycle core
package cpu_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;
    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_SYSTEM = 7'b1110011
    } opcode_t;
    typedef enum logic [2:0] {IMM_I, IMM_SHAMT, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;
    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
        S_MEM = 3'd3, S_WRITEBACK = 3'd4, S_HALT = 3'd5
    } state_t;
    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
    function automatic logic [31:0] imm_ext(input logic [31:0] ir, input imm_type_t t);
        return t == IMM_SHAMT ? {27'b0, ir[24:20]} :
               t == IMM_S     ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
               t == IMM_B     ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
               t == IMM_U     ? {ir[31:12], 12'b0} :
               t == IMM_J     ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
                                {{20{ir[31]}}, ir[31:20]};
    endfunction
    // funct3[0] inverts the base condition (bne/bge/bgeu)
    function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        return f3[0] ^ (f3[2:1] == 2'b00 ? a == b :
                        f3[2:1] == 2'b10 ? $signed(a) < $signed(b) : a < b);
    endfunction
endpackage

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: state register, instruction decode and datapath enables
module mc_control_fsm
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_ir,
    input  logic        i_taken,
    input  logic        i_misaligned,
    output state_t      o_state,
    output alu_op_t     o_alu_op,
    output imm_type_t   o_imm_type,
    output logic        o_use_imm,
    output logic        o_ir_we,
    output logic        o_dec_we,
    output logic        o_alu_we,
    output logic        o_pc_we,
    output logic        o_pc_target,
    output logic        o_rf_we,
    output logic        o_wd_pc4,
    output logic        o_wd_mem,
    output logic        o_mem_we,
    output logic        o_retire,
    output logic [31:0] o_retired_count,
    output logic        o_halted,
    output logic        o_illegal
);
    opcode_t    w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic w_is_op, w_is_opi, w_is_lui, w_is_load, w_is_store, w_is_br, w_is_jal, w_is_sys;
    logic w_env, w_legal, w_ctl, w_jump, w_bad;
    state_t r_state;
    assign w_opc      = opcode_t'(i_ir[6:0]);
    assign w_f3       = i_ir[14:12];
    assign w_f7       = i_ir[31:25];
    assign w_is_op    = w_opc == OPC_OP;
    assign w_is_opi   = w_opc == OPC_OP_IMM;
    assign w_is_lui   = w_opc == OPC_LUI;
    assign w_is_load  = w_opc == OPC_LOAD;
    assign w_is_store = w_opc == OPC_STORE;
    assign w_is_br    = w_opc == OPC_BRANCH;
    assign w_is_jal   = w_opc == OPC_JAL;
    assign w_is_sys   = w_opc == OPC_SYSTEM;
    assign w_env      = i_ir == INSN_ECALL || i_ir == INSN_EBREAK;
    assign w_legal = w_is_op  ? (w_f7 == 7'h00 || (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5))) :
                     w_is_opi ? (w_f3 == 3'd1 ? w_f7 == 7'h00 :
                                 w_f3 == 3'd5 ? (w_f7 == 7'h00 || w_f7 == 7'h20) : 1'b1) :
                     (w_is_lui || w_is_jal)     ? 1'b1 :
                     (w_is_load || w_is_store)  ? w_f3 == 3'd2 :
                     w_is_br  ? w_f3[2:1] != 2'b01 :
                     w_is_sys ? w_env : 1'b0;
    always_comb begin
        o_alu_op = ALU_ADD;
        case (w_f3)
            3'd0: o_alu_op = (w_is_op && w_f7[5]) ? ALU_SUB : ALU_ADD;
            3'd1: o_alu_op = ALU_SLL;
            3'd2: o_alu_op = ALU_SLT;
            3'd3: o_alu_op = ALU_SLTU;
            3'd4: o_alu_op = ALU_XOR;
            3'd5: o_alu_op = w_f7[5] ? ALU_SRA : ALU_SRL;
            3'd6: o_alu_op = ALU_OR;
            3'd7: o_alu_op = ALU_AND;
        endcase
        if (w_is_lui) o_alu_op = ALU_PASSB;
        else if (!(w_is_op || w_is_opi)) o_alu_op = ALU_ADD;
    end
    assign o_imm_type = w_is_opi   ? ((w_f3 == 3'd1 || w_f3 == 3'd5) ? IMM_SHAMT : IMM_I) :
                        w_is_store ? IMM_S :
                        w_is_br    ? IMM_B :
                        w_is_lui   ? IMM_U :
                        w_is_jal   ? IMM_J : IMM_I;
    assign o_use_imm = !w_is_op;
    // a taken control transfer to a non-word address halts without side effects
    assign w_ctl       = w_is_br || w_is_jal;
    assign w_jump      = w_is_jal || (w_is_br && i_taken);
    assign w_bad       = w_jump && i_misaligned;
    assign o_state     = r_state;
    assign o_ir_we     = r_state == S_FETCH;
    assign o_dec_we    = r_state == S_DECODE;
    assign o_alu_we    = r_state == S_EXECUTE;
    assign o_pc_target = r_state == S_EXECUTE && w_jump;
    assign o_pc_we     = (r_state == S_EXECUTE && w_ctl && !w_bad) ||
                         (r_state == S_MEM && w_is_store) || r_state == S_WRITEBACK;
    assign o_rf_we     = (r_state == S_EXECUTE && w_is_jal && !w_bad) || r_state == S_WRITEBACK;
    assign o_wd_pc4    = r_state == S_EXECUTE;
    assign o_wd_mem    = w_is_load;
    assign o_mem_we    = r_state == S_MEM && w_is_store;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_FETCH;
            o_retire        <= 1'b0;
            o_retired_count <= '0;
            o_halted        <= 1'b0;
            o_illegal       <= 1'b0;
        end else begin
            o_retire <= o_pc_we;
            if (o_pc_we) o_retired_count <= o_retired_count + 32'd1;
            case (r_state)
                S_FETCH: r_state <= S_DECODE;
                S_DECODE: begin
                    if (!w_legal || w_env) begin
                        r_state   <= S_HALT;
                        o_halted  <= 1'b1;
                        o_illegal <= !w_legal;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    if (w_bad) begin
                        r_state   <= S_HALT;
                        o_halted  <= 1'b1;
                        o_illegal <= 1'b1;
                    end else begin
                        r_state <= w_ctl ? S_FETCH : (w_is_load || w_is_store) ? S_MEM : S_WRITEBACK;
                    end
                end
                S_MEM:       r_state <= w_is_store ? S_FETCH : S_WRITEBACK;
                S_WRITEBACK: r_state <= S_FETCH;
                default:     r_state <= S_HALT;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: RV32I-subset core with a shared datapath sequenced by mc_control_fsm
module multicycle_cpu
    import cpu_pkg::*;
#(
    parameter int          IMEM_DEPTH = 32,
    parameter int          DMEM_DEPTH = 32,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [IMEM_DEPTH-1:0][31:0] initial_instructions,
    input  logic [31:0][31:0]           initial_register_values,
    input  logic [DMEM_DEPTH-1:0][31:0] initial_data_values,
    output logic [31:0]                 pc_out_check,
    output logic [31:0]                 instruction_check,
    output logic [2:0]                  state_check,
    output logic                        retire,
    output logic [31:0]                 retired_count,
    output logic                        halted,
    output logic                        illegal_instruction,
    output logic [31:0][31:0]           register_check
);
    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int DW = $clog2(DMEM_DEPTH);
    logic [31:0] r_pc, r_ir, r_a, r_b, r_imm, r_alu;
    logic [31:0] r_regs [32];
    logic [31:0] r_dmem [DMEM_DEPTH];
    state_t      w_state;
    alu_op_t     w_alu_op;
    imm_type_t   w_imm_type;
    logic w_use_imm, w_ir_we, w_dec_we, w_alu_we, w_pc_we, w_pc_target;
    logic w_rf_we, w_wd_pc4, w_wd_mem, w_mem_we, w_taken;
    logic [31:0] w_op2, w_alu, w_target, w_pc4, w_wd;
    logic [4:0]  w_rd;
    logic [DW-1:0] w_didx;
    mc_control_fsm u_ctrl (
        .clk             (clk),
        .reset           (reset),
        .i_ir            (r_ir),
        .i_taken         (w_taken),
        .i_misaligned    (w_target[1:0] != 2'b00),
        .o_state         (w_state),
        .o_alu_op        (w_alu_op),
        .o_imm_type      (w_imm_type),
        .o_use_imm       (w_use_imm),
        .o_ir_we         (w_ir_we),
        .o_dec_we        (w_dec_we),
        .o_alu_we        (w_alu_we),
        .o_pc_we         (w_pc_we),
        .o_pc_target     (w_pc_target),
        .o_rf_we         (w_rf_we),
        .o_wd_pc4        (w_wd_pc4),
        .o_wd_mem        (w_wd_mem),
        .o_mem_we        (w_mem_we),
        .o_retire        (retire),
        .o_retired_count (retired_count),
        .o_halted        (halted),
        .o_illegal       (illegal_instruction)
    );
    assign w_op2    = w_use_imm ? r_imm : r_b;
    assign w_target = r_pc + r_imm;
    assign w_pc4    = r_pc + 32'd4;
    assign w_taken  = br_taken(r_ir[14:12], r_a, r_b);
    assign w_rd     = r_ir[11:7];
    // r_alu holds the effective address from EXECUTE onward for loads/stores
    assign w_didx   = r_alu[DW+1:2];
    assign w_wd     = w_wd_pc4 ? w_pc4 : w_wd_mem ? r_dmem[w_didx] : r_alu;
    always_comb begin
        w_alu = r_a + w_op2;
        case (w_alu_op)
            ALU_SUB:   w_alu = r_a - w_op2;
            ALU_SLL:   w_alu = r_a << w_op2[4:0];
            ALU_SLT:   w_alu = {31'b0, $signed(r_a) < $signed(w_op2)};
            ALU_SLTU:  w_alu = {31'b0, r_a < w_op2};
            ALU_XOR:   w_alu = r_a ^ w_op2;
            ALU_SRL:   w_alu = r_a >> w_op2[4:0];
            ALU_SRA:   w_alu = $signed(r_a) >>> w_op2[4:0];
            ALU_OR:    w_alu = r_a | w_op2;
            ALU_AND:   w_alu = r_a & w_op2;
            ALU_PASSB: w_alu = w_op2;
            default:   w_alu = r_a + w_op2;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_ir  <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_imm <= '0;
            r_alu <= '0;
        end else begin
            if (w_ir_we) r_ir <= initial_instructions[r_pc[IW+1:2]];
            if (w_dec_we) begin
                r_a   <= r_regs[r_ir[19:15]];
                r_b   <= r_regs[r_ir[24:20]];
                r_imm <= imm_ext(r_ir, w_imm_type);
            end
            if (w_alu_we) r_alu <= w_alu;
            if (w_pc_we) r_pc <= w_pc_target ? w_target : w_pc4;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= (i == 0) ? 32'd0 : initial_register_values[i];
        end else if (w_rf_we && w_rd != 5'd0) begin
            r_regs[w_rd] <= w_wd;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) r_dmem[i] <= initial_data_values[i];
        end else if (w_mem_we) begin
            r_dmem[w_didx] <= r_b;
        end
    end
    always_comb begin
        register_check = '0;
        for (int i = 0; i < 32; i++) register_check[i] = r_regs[i];
    end
    assign pc_out_check      = r_pc;
    assign instruction_check = r_ir;
    assign state_check       = w_state;
endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed programs with hand-computed results for multicycle_cpu
module tb_multicycle_cpu;
    localparam int ID = 32;
    localparam int DD = 32;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [ID-1:0][31:0] rom;
    logic [31:0][31:0]   rinit;
    logic [DD-1:0][31:0] dinit;
    logic [31:0] pc, ir, rcount;
    logic [2:0]  st;
    logic        retire, halted, illegal;
    logic [31:0][31:0] regs;
    int n_chk = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    multicycle_cpu #(.IMEM_DEPTH(ID), .DMEM_DEPTH(DD), .RESET_PC(32'h0)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .initial_instructions    (rom),
        .initial_register_values (rinit),
        .initial_data_values     (dinit),
        .pc_out_check            (pc),
        .instruction_check       (ir),
        .state_check             (st),
        .retire                  (retire),
        .retired_count           (rcount),
        .halted                  (halted),
        .illegal_instruction     (illegal),
        .register_check          (regs)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic step(input string tag, input int exp_cyc);
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!retire && cyc < 40);
        chk(tag, cyc, exp_cyc);
    endtask
    initial begin
        rom = '0; rinit = '0; dinit = '0;
        // addi x1,x0,5; addi x2,x1,-7; sub x3,x1,x2; srai x4,x2,1; sltu x7,x1,x2
        rom[0] = 32'h00500093; rom[1] = 32'hFF908113; rom[2] = 32'h402081B3;
        rom[3] = 32'h40115213; rom[4] = 32'h0020B3B3;
        do_reset();
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0);
        chk("rst_state", 32'(st), 32'd0);
        chk("rst_count", rcount, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_retire", 32'(retire), 32'd0);
        step("addi1_cyc", 4);
        chk("retire_pulse", 32'(retire), 32'd1);
        chk("count_1", rcount, 32'd1);
        step("addi2_cyc", 4);
        step("sub_cyc", 4);
        step("srai_cyc", 4);
        step("sltu_cyc", 4);
        chk("x1", regs[1], 32'd5);
        chk("x2", regs[2], 32'hFFFFFFFE);
        chk("x3", regs[3], 32'd7);
        chk("x4_sra", regs[4], 32'hFFFFFFFF);
        chk("x7_sltu", regs[7], 32'd1);
        chk("count_5", rcount, 32'd5);
        // sw x5,4(x0); lw x6,4(x0)
        rom = '0; rinit = '0; dinit = '0;
        rinit[5] = 32'h100;
        rom[0] = 32'h00502223; rom[1] = 32'h00402303;
        do_reset();
        step("sw_cyc", 4);
        chk("dmem1_sw", dut.r_dmem[1], 32'h100);
        step("lw_cyc", 5);
        chk("x6_lw", regs[6], 32'h100);
        chk("pc_after_lw", pc, 32'd8);
        // blt x1,x2,+8 (taken); bltu x1,x2,+8 (not taken); ebreak
        rom = '0; rinit = '0; dinit = '0;
        rinit[1] = 32'hFFFFFFFF; rinit[2] = 32'd1;
        rom[0] = 32'h0020C463; rom[2] = 32'h0020E463; rom[3] = 32'h00100073;
        do_reset();
        step("blt_cyc", 3);
        chk("pc_blt", pc, 32'd8);
        step("bltu_cyc", 3);
        chk("pc_bltu", pc, 32'd12);
        repeat (2) @(negedge clk);
        chk("br_halted", 32'(halted), 32'd1);
        chk("br_count", rcount, 32'd2);
        // addi x0,x0,9; nop; jal x1,-4
        rom = '0; rinit = '0; dinit = '0;
        rinit[1] = 32'h55;
        rom[0] = 32'h00900013; rom[1] = 32'h00000013; rom[2] = 32'hFFDFF0EF;
        do_reset();
        step("addi_x0_cyc", 4);
        chk("x0_zero", regs[0], 32'd0);
        step("nop_cyc", 4);
        step("jal_cyc", 3);
        chk("x1_jal", regs[1], 32'd12);
        chk("pc_jal", pc, 32'd4);
        chk("jal_count", rcount, 32'd3);
        // addi x1,x0,5; ebreak
        rom = '0; rinit = '0; dinit = '0;
        rom[0] = 32'h00500093; rom[1] = 32'h00100073;
        do_reset();
        step("pre_ebreak_cyc", 4);
        repeat (2) @(negedge clk);
        chk("ebreak_halted", 32'(halted), 32'd1);
        chk("ebreak_illegal", 32'(illegal), 32'd0);
        chk("ebreak_state", 32'(st), 32'd5);
        chk("ebreak_pc", pc, 32'd4);
        chk("ebreak_count", rcount, 32'd1);
        repeat (5) @(negedge clk);
        chk("halt_pc_frozen", pc, 32'd4);
        chk("halt_count_frozen", rcount, 32'd1);
        chk("halt_no_retire", 32'(retire), 32'd0);
        rom[1] = 32'hFFFFFFFF;
        do_reset();
        step("pre_illegal_cyc", 4);
        repeat (2) @(negedge clk);
        chk("illegal_halted", 32'(halted), 32'd1);
        chk("illegal_flag", 32'(illegal), 32'd1);
        chk("illegal_pc", pc, 32'd4);
        // jal x0,+2: misaligned target halts as illegal with PC unchanged
        rom = '0;
        rom[0] = 32'h0020006F;
        do_reset();
        repeat (3) @(negedge clk);
        chk("mis_halted", 32'(halted), 32'd1);
        chk("mis_illegal", 32'(illegal), 32'd1);
        chk("mis_pc", pc, 32'd0);
        chk("mis_count", rcount, 32'd0);
        // reset asserted in MEM of sw x5,4(x0)
        rom = '0; rinit = '0; dinit = '0;
        rinit[5] = 32'h1234; dinit[1] = 32'hDEAD;
        rom[0] = 32'h00502223;
        do_reset();
        repeat (3) @(negedge clk);
        chk("sw_in_mem", 32'(st), 32'd3);
        reset = 1'b1;
        #1;
        chk("async_pc", pc, 32'h0);
        chk("async_state", 32'(st), 32'd0);
        @(negedge clk);
        chk("abort_dmem", dut.r_dmem[1], 32'hDEAD);
        reset = 1'b0;
        step("sw_rerun_cyc", 4);
        chk("sw_rerun_dmem", dut.r_dmem[1], 32'h1234);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
